// File: rtl/alu_mul_ctrl_if.sv
// rtl/alu_mul_ctrl_if.sv - request/product handshake and ALU drive bundle for alu_mul_ctrl
interface alu_mul_ctrl_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;
    logic [2:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_r;
    logic       alu_c;

    // master is the requester plus the ALU it lends; slave is the sequencer
    modport master (
        output start, A, B, alu_r, alu_c,
        input  busy, done, P, alu_op, alu_a, alu_b
    );

    modport slave (
        input  start, A, B, alu_r, alu_c,
        output busy, done, P, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_ctrl.sv
// rtl/alu_mul_ctrl.sv - shift-and-add 4x4 unsigned multiply sequencer driving an external 4-bit ALU
module alu_mul_ctrl (
    input  logic            clk,
    input  logic            reset,
    alu_mul_ctrl_if.slave   bus
);
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] mcand;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] cnt;
    logic [7:0] prod;
    logic       done_q;

    logic [2:0] op_c;
    logic [3:0] a_c;
    logic [3:0] b_c;
    logic       busy_c;
    logic       last_iter;
    logic [7:0] shifted;

    assign last_iter = (cnt == 2'd3);
    // {carry, sum, low half} shifted right by one; the dropped bit is the consumed multiplier bit
    assign shifted   = {bus.alu_c, bus.alu_r, lo[3:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_c      = OP_PASS;
        a_c       = 4'd0;
        b_c       = 4'd0;
        busy_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                a_c    = hi;
                b_c    = mcand;
                op_c   = lo[0] ? OP_ADD : OP_PASS;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= 4'd0;
            hi     <= 4'd0;
            lo     <= 4'd0;
            cnt    <= 2'd0;
            prod   <= 8'h00;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.A;
                        lo    <= bus.B;
                        hi    <= 4'd0;
                        cnt   <= 2'd0;
                    end
                end
                RUN: begin
                    {hi, lo} <= shifted;
                    cnt      <= cnt + 2'd1;
                    if (last_iter) begin
                        prod   <= shifted;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.alu_op = op_c;
    assign bus.alu_a  = a_c;
    assign bus.alu_b  = b_c;
    assign bus.busy   = busy_c;
    assign bus.done   = done_q;
    assign bus.P      = prod;
endmodule

// File: tb/tb_alu_mul_ctrl.sv
// tb/tb_alu_mul_ctrl.sv - directed-vector bench for alu_mul_ctrl with a behavioural ALU
module tb_alu_mul_ctrl;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    int   n_done;

    alu_mul_ctrl_if bus ();

    alu_mul_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign {bus.alu_c, bus.alu_r} = (bus.alu_op == 3'b010)
                                    ? ({1'b0, bus.alu_a} + {1'b0, bus.alu_b})
                                    : {1'b0, bus.alu_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // add_mask bit i (LSB first) says whether iteration i must issue an add
    task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] add_mask, input logic [7:0] exp_p);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("op[%0d] %0dx%0d", i, a, b), {29'd0, bus.alu_op},
                add_mask[i] ? 32'd2 : 32'd0);
            chk($sformatf("alu_b[%0d] %0dx%0d", i, a, b), {28'd0, bus.alu_b}, {28'd0, a});
            chk($sformatf("busy run %0dx%0d", i, a, b), {31'd0, bus.busy}, 32'd1);
            chk($sformatf("done run %0dx%0d", i, a, b), {31'd0, bus.done}, 32'd0);
            @(negedge clk);
        end
        chk($sformatf("done %0dx%0d", a, b), {31'd0, bus.done}, 32'd1);
        chk($sformatf("P %0dx%0d", a, b), {24'd0, bus.P}, {24'd0, exp_p});
        @(negedge clk);
        chk($sformatf("idle busy %0dx%0d", a, b), {31'd0, bus.busy}, 32'd0);
        chk($sformatf("idle done %0dx%0d", a, b), {31'd0, bus.done}, 32'd0);
        chk($sformatf("hold P %0dx%0d", a, b), {24'd0, bus.P}, {24'd0, exp_p});
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 4'd0;
        bus.B     = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset P", {24'd0, bus.P}, 32'h00);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset op", {29'd0, bus.alu_op}, 32'd0);
        chk("reset alu_a", {28'd0, bus.alu_a}, 32'd0);
        chk("reset alu_b", {28'd0, bus.alu_b}, 32'd0);

        run_mul(4'd3,  4'd5,  4'b0101, 8'h0F);
        run_mul(4'd15, 4'd15, 4'b1111, 8'hE1);
        run_mul(4'd0,  4'd9,  4'b1001, 8'h00);
        run_mul(4'd7,  4'd0,  4'b0000, 8'h00);

        // start re-asserted during RUN and DONE must be dropped
        bus.A     = 4'd2;
        bus.B     = 4'd6;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.A  = 4'd9;
        bus.B  = 4'd9;
        n_done = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.done) n_done++;
            if (c == 5) begin
                chk("ignore P", {24'd0, bus.P}, 32'h0C);
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ignore done count", n_done, 32'd1);
        chk("ignore idle busy", {31'd0, bus.busy}, 32'd0);

        // start held high: one product every six cycles
        bus.A     = 4'd4;
        bus.B     = 4'd4;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 18) bus.start = 1'b0;
            if (c % 6 == 5) begin
                chk($sformatf("b2b done c%0d", c), {31'd0, bus.done}, 32'd1);
                chk($sformatf("b2b P c%0d", c), {24'd0, bus.P}, 32'h10);
            end else begin
                chk($sformatf("b2b no done c%0d", c), {31'd0, bus.done}, 32'd0);
            end
        end
        @(negedge clk);

        // reset mid-RUN aborts and clears P
        bus.A     = 4'd15;
        bus.B     = 4'd15;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        chk("abort P", {24'd0, bus.P}, 32'h00);
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            if (bus.done) n_done++;
            @(negedge clk);
        end
        chk("abort no done", n_done, 32'd0);
        chk("abort still idle", {31'd0, bus.busy}, 32'd0);
        run_mul(4'd2, 4'd3, 4'b0011, 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
